// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: legal store byte-enable
// patterns, sweep FSM states, trace record layout and error flag positions.
package dm_pkg;

  localparam logic [3:0] BYTEEN_WORD    = 4'b1111;
  localparam logic [3:0] BYTEEN_HALF_LO = 4'b0011;
  localparam logic [3:0] BYTEEN_HALF_HI = 4'b1100;
  localparam logic [3:0] BYTEEN_B0      = 4'b0001;
  localparam logic [3:0] BYTEEN_B1      = 4'b0010;
  localparam logic [3:0] BYTEEN_B2      = 4'b0100;
  localparam logic [3:0] BYTEEN_B3      = 4'b1000;

  typedef enum logic {
    DM_STATE_CLEAR,
    DM_STATE_RUN
  } dm_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  localparam int unsigned ERR_OUT_OF_RANGE = 0;
  localparam int unsigned ERR_BAD_BYTEEN   = 1;
  localparam int unsigned ERR_OVERFLOW     = 2;

  function automatic logic byteen_legal(input logic [3:0] be);
    case (be)
      BYTEEN_WORD, BYTEEN_HALF_LO, BYTEEN_HALF_HI,
      BYTEEN_B0, BYTEEN_B1, BYTEEN_B2, BYTEEN_B3: byteen_legal = 1'b1;
      default:                                    byteen_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Valid/ready FIFO for store trace records; a push while full is accepted
// only when the head is popped in the same cycle.
module trace_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       ready,
  output logic                       valid,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_acc;
  logic             pop_acc;

  always_comb begin
    empty    = (count == '0);
    full     = (count == (PW+1)'(DEPTH));
    valid    = !empty;
    head     = store[rd_ptr];
    pop_acc  = ready && !empty;
    push_acc = push && (!full || pop_acc);
  end

  always_ff @(posedge clk) begin
    if (push_acc) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: combinational word reads, byte-enabled stores,
// post-reset zero-fill sweep and a trace record per committed store.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_WORDS  = 3072,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   m_data_addr,
  input  logic [31:0]                   m_data_wdata,
  input  logic [3:0]                    m_data_byteen,
  input  logic [31:0]                   m_inst_addr,
  output logic [31:0]                   m_data_rdata,
  output logic                          init_done,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [31:0]                   trace_pc,
  output logic [31:0]                   trace_addr,
  output logic [31:0]                   trace_data,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count,
  output logic [2:0]                    err_flags
);

  localparam int unsigned AW = $clog2(ADDR_WORDS);

  logic [31:0] mem [ADDR_WORDS];
  dm_state_e   state;
  logic [AW-1:0] ptr;

  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic          store_req;
  logic          store_ok;
  logic          fifo_full;
  logic          fifo_empty;
  trace_rec_t    push_rec;
  trace_rec_t    head_rec;

  always_comb begin
    in_range  = (m_data_addr < 32'(4 * ADDR_WORDS));
    idx       = m_data_addr[AW+1:2];
    old_word  = in_range ? mem[idx] : '0;
    merged    = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
    end
    store_req = (state == DM_STATE_RUN) && (m_data_byteen != 4'b0000);
    store_ok  = store_req && in_range && byteen_legal(m_data_byteen);
    m_data_rdata = (state == DM_STATE_RUN) ? old_word : '0;
    push_rec  = '{pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00}, data: merged};
  end

  // Array is deliberately unreset: stale contents persist until the sweep reaches them.
  always_ff @(posedge clk) begin
    if (state == DM_STATE_CLEAR) mem[ptr] <= '0;
    else if (store_ok)           mem[idx] <= merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DM_STATE_CLEAR;
      ptr       <= '0;
      init_done <= 1'b0;
      err_flags <= '0;
    end else begin
      case (state)
        DM_STATE_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == AW'(ADDR_WORDS - 1)) begin
            state     <= DM_STATE_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          if (store_req && !in_range)
            err_flags[ERR_OUT_OF_RANGE] <= 1'b1;
          if (store_req && !byteen_legal(m_data_byteen))
            err_flags[ERR_BAD_BYTEEN] <= 1'b1;
          if (store_ok && fifo_full && !trace_ready)
            err_flags[ERR_OVERFLOW] <= 1'b1;
        end
      endcase
    end
  end

  trace_fifo #(
    .WIDTH ($bits(trace_rec_t)),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (store_ok),
    .push_data (push_rec),
    .ready     (trace_ready),
    .valid     (trace_valid),
    .head      (head_rec),
    .count     (trace_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    trace_pc   = head_rec.pc;
    trace_addr = head_rec.addr;
    trace_data = head_rec.data;
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: zero-fill sweep, table of single stores,
// then reset mid-stream, FIFO overflow, full push+pop and drain order.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        init_done;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [3:0]  trace_count;
  logic [2:0]  err_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_WORDS(3072), .TRACE_DEPTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .init_done     (init_done),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_pc      (trace_pc),
    .trace_addr    (trace_addr),
    .trace_data    (trace_data),
    .trace_count   (trace_count),
    .err_flags     (err_flags)
  );

  typedef struct {
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] exp_old;
    logic [31:0] rd_addr;
    logic [31:0] exp_word;
    logic        exp_valid;
    logic [31:0] exp_taddr;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sweep_wait();
    int bad = 0;
    m_data_addr = 32'h10;
    for (int i = 0; i < 3071; i++) begin
      @(negedge clk); #1;
      if (m_data_rdata !== 32'h0 || init_done !== 1'b0) bad++;
    end
    chk("sweep_rdata_init_low", 32'(bad), 32'h0);
    @(negedge clk); #1;
    chk("init_done_rise", {31'h0, init_done}, 32'h1);
  endtask

  task automatic store(input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc);
    m_data_byteen = be;
    m_data_addr   = addr;
    m_data_wdata  = wdata;
    m_inst_addr   = pc;
  endtask

  initial begin
    vecs[0] = '{4'b1111, 32'h100,  32'h12345678, 32'h3000, 32'h0,        32'h100,  32'h12345678, 1'b1, 32'h100,  3'b000};
    vecs[1] = '{4'b0100, 32'h102,  32'h00AB0000, 32'h3004, 32'h12345678, 32'h100,  32'h12AB5678, 1'b1, 32'h100,  3'b000};
    vecs[2] = '{4'b0011, 32'h100,  32'h0000BEEF, 32'h3008, 32'h12AB5678, 32'h100,  32'h12ABBEEF, 1'b1, 32'h100,  3'b000};
    vecs[3] = '{4'b1100, 32'h103,  32'hCAFE0000, 32'h300C, 32'h12ABBEEF, 32'h100,  32'hCAFEBEEF, 1'b1, 32'h100,  3'b000};
    vecs[4] = '{4'b0001, 32'h200,  32'h00000011, 32'h3010, 32'h0,        32'h200,  32'h00000011, 1'b1, 32'h200,  3'b000};
    vecs[5] = '{4'b1000, 32'h2FFC, 32'h99000000, 32'h3014, 32'h0,        32'h2FFC, 32'h99000000, 1'b1, 32'h2FFC, 3'b000};
    vecs[6] = '{4'b0010, 32'h201,  32'h00002200, 32'h3018, 32'h00000011, 32'h200,  32'h00002211, 1'b1, 32'h200,  3'b000};
    vecs[7] = '{4'b0000, 32'h200,  32'hFFFFFFFF, 32'h301C, 32'h00002211, 32'h200,  32'h00002211, 1'b0, 32'h0,    3'b000};
    vecs[8] = '{4'b0110, 32'h100,  32'hFFFFFFFF, 32'h3020, 32'hCAFEBEEF, 32'h100,  32'hCAFEBEEF, 1'b0, 32'h0,    3'b010};
    vecs[9] = '{4'b1111, 32'h3000, 32'hFFFFFFFF, 32'h3024, 32'h0,        32'h2FFC, 32'h99000000, 1'b0, 32'h0,    3'b011};

    reset = 1'b0;
    trace_ready = 1'b0;
    store(4'b0000, 32'h10, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_init_done", {31'h0, init_done}, 32'h0);
    chk("rst_valid", {31'h0, trace_valid}, 32'h0);
    chk("rst_count", {28'h0, trace_count}, 32'h0);
    chk("rst_flags", {29'h0, err_flags}, 32'h0);
    chk("rst_rdata", m_data_rdata, 32'h0);
    reset = 1'b1;
    sweep_wait();

    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      store(vecs[v].be, vecs[v].addr, vecs[v].wdata, vecs[v].pc);
      trace_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_same_cycle_rdata", v), m_data_rdata, vecs[v].exp_old);
      @(negedge clk);
      store(4'b0000, vecs[v].rd_addr, 32'h0, 32'h0);
      #1;
      chk($sformatf("v%0d_rdata", v), m_data_rdata, vecs[v].exp_word);
      chk($sformatf("v%0d_valid", v), {31'h0, trace_valid}, {31'h0, vecs[v].exp_valid});
      chk($sformatf("v%0d_flags", v), {29'h0, err_flags}, {29'h0, vecs[v].exp_flags});
      if (vecs[v].exp_valid) begin
        chk($sformatf("v%0d_tpc", v), trace_pc, vecs[v].pc);
        chk($sformatf("v%0d_taddr", v), trace_addr, vecs[v].exp_taddr);
        chk($sformatf("v%0d_tdata", v), trace_data, vecs[v].exp_word);
      end
      trace_ready = 1'b1;
      @(negedge clk);
      trace_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_count_after_pop", v), {28'h0, trace_count}, 32'h0);
    end

    // Reset mid-stream with one record queued.
    @(negedge clk);
    store(4'b1111, 32'h104, 32'h5555AAAA, 32'h4000);
    @(negedge clk);
    store(4'b0000, 32'h104, 32'h0, 32'h0);
    #1;
    chk("mid_valid_before_reset", {31'h0, trace_valid}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, trace_valid}, 32'h0);
    chk("mid_rst_count", {28'h0, trace_count}, 32'h0);
    chk("mid_rst_flags", {29'h0, err_flags}, 32'h0);
    chk("mid_rst_init_done", {31'h0, init_done}, 32'h0);
    chk("mid_rst_rdata", m_data_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    // Stores during the sweep are dropped; the sweep itself reads as 0 at 0x10.
    store(4'b1111, 32'h10, 32'hDEADBEEF, 32'h4004);
    repeat (5) @(negedge clk);
    #1;
    chk("clear_store_rdata", m_data_rdata, 32'h0);
    chk("clear_store_count", {28'h0, trace_count}, 32'h0);
    chk("clear_store_flags", {29'h0, err_flags}, 32'h0);
    store(4'b0000, 32'h10, 32'h0, 32'h0);
    repeat (3066) @(negedge clk);
    #1;
    chk("resweep_init_low", {31'h0, init_done}, 32'h0);
    @(negedge clk);
    #1;
    chk("resweep_init_high", {31'h0, init_done}, 32'h1);
    m_data_addr = 32'h100;  #1; chk("swept_0x100",  m_data_rdata, 32'h0);
    m_data_addr = 32'h104;  #1; chk("swept_0x104",  m_data_rdata, 32'h0);
    m_data_addr = 32'h2FFC; #1; chk("swept_0x2FFC", m_data_rdata, 32'h0);
    m_data_addr = 32'h10;   #1; chk("swept_0x10",   m_data_rdata, 32'h0);

    // Overflow: nine stores with the consumer stalled.
    trace_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      store(4'b1111, 32'h400 + 32'(4 * k), 32'hA0000000 + 32'(k), 32'h5000 + 32'(4 * k));
    end
    @(negedge clk);
    store(4'b0000, 32'h420, 32'h0, 32'h0);
    #1;
    chk("ovf_count", {28'h0, trace_count}, 32'h8);
    chk("ovf_flags", {29'h0, err_flags}, 32'h4);
    chk("ovf_9th_in_mem", m_data_rdata, 32'hA0000008);
    chk("ovf_head_pc", trace_pc, 32'h5000);
    chk("ovf_head_data", trace_data, 32'hA0000000);
    @(negedge clk);
    #1;
    chk("stall_head_stable", trace_pc, 32'h5000);

    // Full FIFO: pop and push in the same cycle.
    store(4'b1111, 32'h424, 32'hA0000009, 32'h5024);
    trace_ready = 1'b1;
    @(negedge clk);
    store(4'b0000, 32'h424, 32'h0, 32'h0);
    trace_ready = 1'b0;
    #1;
    chk("full_pushpop_count", {28'h0, trace_count}, 32'h8);
    chk("full_pushpop_flags", {29'h0, err_flags}, 32'h4);
    chk("full_pushpop_mem", m_data_rdata, 32'hA0000009);

    for (int j = 0; j < 8; j++) begin
      int k;
      k = (j < 7) ? j + 1 : 9;
      chk($sformatf("drain%0d_valid", j), {31'h0, trace_valid}, 32'h1);
      chk($sformatf("drain%0d_pc", j), trace_pc, 32'h5000 + 32'(4 * k));
      chk($sformatf("drain%0d_addr", j), trace_addr, 32'h400 + 32'(4 * k));
      chk($sformatf("drain%0d_data", j), trace_data, 32'hA0000000 + 32'(k));
      trace_ready = 1'b1;
      @(negedge clk);
      trace_ready = 1'b0;
      #1;
    end
    chk("drain_count", {28'h0, trace_count}, 32'h0);
    chk("drain_valid", {31'h0, trace_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
